// File: rtl/multdiv_ctrl_pkg.sv
// Shared decode constants, state encoding and decode helper for the
// multiplier/divider sequencer.
package multdiv_ctrl_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [31:0] RSTATUS_MUL = 32'd4;
  localparam logic [31:0] RSTATUS_DIV = 32'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // True when the opcode/ALU-op fields name an R-type mul or div.
  function automatic logic is_md_op(input logic [4:0] opcode, input logic [4:0] alu_op);
    return (opcode == OP_RTYPE) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));
  endfunction

endpackage

// File: rtl/multdiv_ctrl_counter.sv
// Cycle counter for the BUSY phase of the multiplier/divider sequencer;
// flags the last allowed BUSY cycle before forced completion.
module md_cycle_counter #(
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// X-stage sequencer for the multi-cycle multiplier/divider: issues start
// pulses, stalls the front of the pipe and hands the result to XM for one cycle.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      dx_ir,
  input  logic             dx_valid,
  input  logic             kill,
  input  logic             md_ready,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic             stall,
  output logic             md_done,
  output logic [WIDTH-1:0] res_out,
  output logic             exc_out,
  output logic [31:0]      rstatus_code
);

  md_state_e state_q, state_d;

  logic is_md;
  logic is_div_op;
  logic is_div_q;
  logic start;
  logic latch_ready;
  logic latch_timeout;
  logic cnt_tc;
  logic unused_ir_bits;

  assign is_md          = dx_valid & is_md_op(dx_ir[31:27], dx_ir[6:2]);
  assign is_div_op      = (dx_ir[6:2] == ALU_DIV);
  assign unused_ir_bits = ^{dx_ir[26:7], dx_ir[1:0]};
  assign start          = ctrl_MULT | ctrl_DIV;

  md_cycle_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (state_q != BUSY),
    .enable   (state_q == BUSY),
    .terminal (cnt_tc)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      res_out  <= '0;
      exc_out  <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        is_div_q <= is_div_op;
      end
      if (latch_ready) begin
        res_out <= md_result;
        exc_out <= md_exception;
      end else if (latch_timeout) begin
        res_out <= '0;
        exc_out <= 1'b1;
      end
    end
  end

  // kill overrides every state, so a flushed op can neither latch nor complete.
  always_comb begin
    state_d       = state_q;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    stall         = 1'b0;
    md_done       = 1'b0;
    latch_ready   = 1'b0;
    latch_timeout = 1'b0;
    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_md) begin
            stall     = 1'b1;
            ctrl_MULT = ~is_div_op;
            ctrl_DIV  = is_div_op;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          stall = 1'b1;
          if (md_ready) begin
            latch_ready = 1'b1;
            state_d     = DONE;
          end else if (cnt_tc) begin
            latch_timeout = 1'b1;
            state_d       = DONE;
          end
        end
        DONE: begin
          md_done = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rstatus_code = exc_out ? (is_div_q ? RSTATUS_DIV : RSTATUS_MUL) : 32'd0;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Randomized self-checking bench for multdiv_ctrl, checked against a
// transaction-level model of start/stall/done timing and result latching.
module tb_multdiv_ctrl;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 40;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [31:0]      dx_ir = '0;
  logic             dx_valid = 1'b0;
  logic             kill = 1'b0;
  logic             md_ready = 1'b0;
  logic [WIDTH-1:0] md_result = '0;
  logic             md_exception = 1'b0;
  logic             ctrl_MULT, ctrl_DIV, stall, md_done, exc_out;
  logic [WIDTH-1:0] res_out;
  logic [31:0]      rstatus_code;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model_res = '0;
  logic        model_exc = 1'b0;

  multdiv_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
    .clock        (clock),
    .reset        (reset),
    .dx_ir        (dx_ir),
    .dx_valid     (dx_valid),
    .kill         (kill),
    .md_ready     (md_ready),
    .md_result    (md_result),
    .md_exception (md_exception),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .stall        (stall),
    .md_done      (md_done),
    .res_out      (res_out),
    .exc_out      (exc_out),
    .rstatus_code (rstatus_code)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Control outputs packed as {ctrl_MULT, ctrl_DIV, stall, md_done}.
  task automatic checkCtl(input string tag, input logic e_mult, input logic e_div,
                          input logic e_stall, input logic e_done);
    checkOutput({tag, ".ctl"}, {28'd0, ctrl_MULT, ctrl_DIV, stall, md_done},
                {28'd0, e_mult, e_div, e_stall, e_done});
  endtask

  function automatic logic [31:0] mdInstr(input bit is_div);
    logic [31:0] ir;
    ir = $urandom;
    ir[31:27] = 5'b00000;
    ir[6:2] = is_div ? 5'b00111 : 5'b00110;
    return ir;
  endfunction

  function automatic logic [31:0] otherInstr();
    logic [31:0] ir;
    ir = $urandom;
    if (ir[31:27] == 5'b00000 && (ir[6:2] == 5'b00110 || ir[6:2] == 5'b00111)) ir[31] = 1'b1;
    return ir;
  endfunction

  // Idle traffic: non-md instructions, bubbles carrying md encodings, stray kills/readies.
  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clock); #1;
      dx_valid     = 1'($urandom_range(0, 1));
      dx_ir        = dx_valid ? otherInstr() : mdInstr(1'($urandom_range(0, 1)));
      kill         = ($urandom_range(0, 3) == 0);
      md_ready     = 1'($urandom_range(0, 1));
      md_result    = $urandom;
      md_exception = 1'($urandom_range(0, 1));
      @(negedge clock);
      checkCtl("idle", 0, 0, 0, 0);
      checkOutput("idle.res", res_out, model_res);
    end
    @(posedge clock); #1;
    kill = 1'b0; md_ready = 1'b0; dx_valid = 1'b0;
  endtask

  // One mul/div transaction: k = BUSY cycle of md_ready (0 = never), kill_at = BUSY cycle of kill (0 = none).
  task automatic applyStimulus(input bit is_div, input int k, input logic [31:0] result,
                               input bit exc, input int kill_at, input string tag);
    bit by_ready;
    int last;
    logic [31:0] exp_rs;
    by_ready = (k >= 1 && k <= TIMEOUT);
    last = by_ready ? k : TIMEOUT;
    @(posedge clock); #1;
    dx_ir = mdInstr(is_div); dx_valid = 1'b1; kill = 1'b0; md_ready = 1'b0;
    md_result = $urandom; md_exception = 1'($urandom_range(0, 1));
    @(negedge clock);
    checkCtl({tag, ".start"}, !is_div, is_div, 1, 0);
    for (int i = 1; i <= last; i++) begin
      @(posedge clock); #1;
      md_ready     = (i == k);
      md_result    = (i == k) ? result : $urandom;
      md_exception = (i == k) ? exc : 1'($urandom_range(0, 1));
      kill         = (i == kill_at);
      @(negedge clock);
      if (i == kill_at) begin
        checkCtl({tag, ".kill"}, 0, 0, 0, 0);
        @(posedge clock); #1;
        kill = 1'b0; dx_valid = 1'b0; md_ready = 1'b1; md_result = $urandom; md_exception = 1'b1;
        @(negedge clock);
        checkCtl({tag, ".late"}, 0, 0, 0, 0);
        @(posedge clock); #1;
        md_ready = 1'b0;
        @(negedge clock);
        checkCtl({tag, ".after"}, 0, 0, 0, 0);
        checkOutput({tag, ".keep_res"}, res_out, model_res);
        checkOutput({tag, ".keep_exc"}, {31'd0, exc_out}, {31'd0, model_exc});
        return;
      end
      checkCtl({tag, ".busy"}, 0, 0, 1, 0);
    end
    @(posedge clock); #1;
    md_ready = 1'b0; md_result = $urandom;
    model_res = by_ready ? result : 32'd0;
    model_exc = by_ready ? exc : 1'b1;
    exp_rs = model_exc ? (is_div ? 32'd5 : 32'd4) : 32'd0;
    @(negedge clock);
    checkCtl({tag, ".done"}, 0, 0, 0, 1);
    checkOutput({tag, ".res"}, res_out, model_res);
    checkOutput({tag, ".exc"}, {31'd0, exc_out}, {31'd0, model_exc});
    checkOutput({tag, ".rstatus"}, rstatus_code, exp_rs);
  endtask

  initial begin
    int k;
    int kill_at;
    int r;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checkCtl("reset", 0, 0, 0, 0);
    checkOutput("reset.res", res_out, 32'd0);
    checkOutput("reset.exc", {31'd0, exc_out}, 32'd0);
    checkOutput("reset.rstatus", rstatus_code, 32'd0);

    applyStimulus(0, 17, 32'h0000_0015, 0, 0, "t1_mul");
    applyStimulus(1, 9, $urandom, 1, 0, "t2_divexc");
    applyStimulus(0, 12, $urandom, 1, 0, "t2_mulexc");
    applyStimulus(0, 0, $urandom, 0, 0, "t3_timeout");
    applyStimulus(1, TIMEOUT, 32'hCAFE_0001, 0, 0, "t3_edge");
    applyStimulus(0, 5, $urandom, 0, 0, "t4_mul");
    applyStimulus(1, 6, 32'h1234_5678, 0, 0, "t4_div");
    applyStimulus(0, 8, $urandom, 1, 5, "t5_kill");
    idleCycles(4);

    // Synchronous reset in the middle of a BUSY phase.
    @(posedge clock); #1;
    dx_ir = mdInstr(0); dx_valid = 1'b1; kill = 1'b0; md_ready = 1'b0;
    @(negedge clock);
    checkCtl("t6.start", 1, 0, 1, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0; dx_valid = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    model_res = '0; model_exc = 1'b0;
    @(negedge clock);
    checkCtl("t6.after", 0, 0, 0, 0);
    checkOutput("t6.res", res_out, 32'd0);
    checkOutput("t6.exc", {31'd0, exc_out}, 32'd0);
    checkOutput("t6.rstatus", rstatus_code, 32'd0);
    applyStimulus(0, 3, 32'h0BAD_F00D, 0, 0, "t6_clean");

    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) k = 0;
      else if (r == 1) k = $urandom_range(TIMEOUT - 2, TIMEOUT + 5);
      else k = $urandom_range(1, 20);
      kill_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : 0;
      applyStimulus(1'($urandom_range(0, 1)), k, $urandom, 1'($urandom_range(0, 1)), kill_at, "rnd");
      idleCycles($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
